// File: rtl/sync_link_sequencer_if.sv
// rtl/sync_link_sequencer_if.sv - link between the sequencer and the synchronizer it controls
interface sync_link_sequencer_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] sync_dout;
    logic             sync_stable;
    logic             sync_resetn;

    modport master (
        input  sync_dout,
        input  sync_stable,
        output sync_resetn
    );

    modport slave (
        output sync_dout,
        output sync_stable,
        input  sync_resetn
    );
endinterface

// File: rtl/sync_link_sequencer.sv
// rtl/sync_link_sequencer.sv - flushes a synchronizer, waits for it to settle, publishes qualified data
module sync_link_sequencer #(
    parameter int WIDTH          = 1,
    parameter int FLUSH_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int GLITCH_LIMIT   = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic                  fault_clear,
    sync_link_sequencer_if.master sync,
    output logic [WIDTH-1:0]      dout,
    output logic                  ready,
    output logic                  change,
    output logic                  fault,
    output logic [1:0]            fault_code
);

    localparam int FLUSH_C   = (FLUSH_CYCLES < 2) ? 2 : FLUSH_CYCLES;
    localparam int TIMEOUT_C = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
    localparam int GLITCH_C  = (GLITCH_LIMIT < 1) ? 1 : GLITCH_LIMIT;

    localparam int FW = $clog2(FLUSH_C);
    localparam int TW = (TIMEOUT_C > 1) ? $clog2(TIMEOUT_C) : 1;
    localparam int GW = (GLITCH_C > 1) ? $clog2(GLITCH_C) : 1;

    localparam logic [FW-1:0] FLUSH_LAST   = FW'(FLUSH_C - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_C - 1);
    localparam logic [GW-1:0] GLITCH_LAST  = GW'(GLITCH_C - 1);

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_TIMEOUT = 2'b01;
    localparam logic [1:0] CODE_LOST    = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_SETTLE,
        ST_RUN,
        ST_FAULT
    } state_t;

    state_t           state, state_nxt;
    logic [FW-1:0]    flush_cnt, flush_nxt;
    logic [TW-1:0]    timer, timer_nxt;
    logic [GW-1:0]    glitch_cnt, glitch_nxt;
    logic [WIDTH-1:0] dout_nxt;
    logic             change_nxt;
    logic [1:0]       code_nxt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            flush_cnt  <= '0;
            timer      <= '0;
            glitch_cnt <= '0;
            dout       <= '0;
            change     <= 1'b0;
            fault_code <= CODE_NONE;
        end else begin
            flush_cnt  <= flush_nxt;
            timer      <= timer_nxt;
            glitch_cnt <= glitch_nxt;
            dout       <= dout_nxt;
            change     <= change_nxt;
            fault_code <= code_nxt;
        end
    end

    // Dropping enable outranks timeout and glitch detection so no fault is latched.
    always_comb begin
        state_nxt  = state;
        flush_nxt  = flush_cnt;
        timer_nxt  = timer;
        glitch_nxt = glitch_cnt;
        dout_nxt   = dout;
        change_nxt = 1'b0;
        code_nxt   = fault_code;
        case (state)
            ST_IDLE: begin
                dout_nxt = '0;
                if (enable) begin
                    state_nxt = ST_FLUSH;
                    flush_nxt = '0;
                end
            end
            ST_FLUSH: begin
                if (!enable) begin
                    state_nxt = ST_IDLE;
                end else if (flush_cnt == FLUSH_LAST) begin
                    state_nxt = ST_SETTLE;
                    timer_nxt = '0;
                end else begin
                    flush_nxt = flush_cnt + FW'(1);
                end
            end
            ST_SETTLE: begin
                if (!enable) begin
                    state_nxt = ST_IDLE;
                end else if (sync.sync_stable) begin
                    state_nxt  = ST_RUN;
                    dout_nxt   = sync.sync_dout;
                    glitch_nxt = '0;
                end else if (timer == TIMEOUT_LAST) begin
                    state_nxt = ST_FAULT;
                    code_nxt  = CODE_TIMEOUT;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_nxt = ST_IDLE;
                end else if (sync.sync_stable) begin
                    dout_nxt   = sync.sync_dout;
                    change_nxt = (sync.sync_dout != dout);
                    glitch_nxt = '0;
                end else if (glitch_cnt == GLITCH_LAST) begin
                    state_nxt = ST_FAULT;
                    code_nxt  = CODE_LOST;
                end else begin
                    glitch_nxt = glitch_cnt + GW'(1);
                end
            end
            ST_FAULT: begin
                if (fault_clear) begin
                    state_nxt = ST_IDLE;
                    code_nxt  = CODE_NONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign sync.sync_resetn = (state == ST_SETTLE) || (state == ST_RUN);
    assign ready            = (state == ST_RUN);
    assign fault            = (state == ST_FAULT);

endmodule

// File: tb/tb_sync_link_sequencer.sv
// tb/tb_sync_link_sequencer.sv - scoreboard bench for sync_link_sequencer
module tb_sync_link_sequencer;

    localparam int EV_RDY = 0;
    localparam int EV_CHG = 1;
    localparam int EV_FLT = 2;

    typedef struct {
        int         kind;
        logic [3:0] val;
    } ev_t;

    logic       clk;
    logic       resetn;
    logic       enable;
    logic       fault_clear;
    logic [3:0] dout;
    logic       ready;
    logic       change;
    logic       fault;
    logic [1:0] fault_code;

    int  tests;
    int  fails;
    int  n;
    ev_t exp_q[$];

    sync_link_sequencer_if #(.WIDTH(4)) sif ();

    sync_link_sequencer #(
        .WIDTH(4),
        .FLUSH_CYCLES(4),
        .TIMEOUT_CYCLES(16),
        .GLITCH_LIMIT(8)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .enable(enable),
        .fault_clear(fault_clear),
        .sync(sif.master),
        .dout(dout),
        .ready(ready),
        .change(change),
        .fault(fault),
        .fault_code(fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input int kind, input logic [3:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic got_ev(input int kind, input logic [3:0] val);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: got event %0d value %0h, expected none", kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== val) begin
                fails++;
                $display("FAIL sb_event: got event %0d value %0h, expected event %0d value %0h",
                         kind, val, e.kind, e.val);
            end
        end
    endtask

    // Monitor: ready rise, change pulse and fault rise are the observable responses.
    logic ready_q, fault_q;
    initial begin
        ready_q = 1'b0;
        fault_q = 1'b0;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (ready && !ready_q) got_ev(EV_RDY, dout);
                if (change) got_ev(EV_CHG, dout);
                if (fault && !fault_q) got_ev(EV_FLT, {2'b00, fault_code});
            end
            ready_q = ready;
            fault_q = fault;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic count_low(output int cnt);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sif.sync_resetn) break;
            cnt++;
        end
    endtask

    initial begin
        tests           = 0;
        fails           = 0;
        resetn          = 1'b0;
        enable          = 1'b0;
        fault_clear     = 1'b0;
        sif.sync_dout   = 4'h0;
        sif.sync_stable = 1'b0;

        repeat (2) @(posedge clk);
        at_neg();
        chk("rst_sync_resetn", 32'(sif.sync_resetn), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_change", 32'(change), 0);
        chk("rst_code", 32'(fault_code), 0);

        // Bring-up: 1 IDLE + 4 FLUSH cycles low, stable on 3rd SETTLE cycle.
        cyc();
        resetn = 1'b1;
        enable = 1'b1;
        count_low(n);
        chk("bringup_low_cycles", 32'(n), 5);
        cyc();
        cyc();
        sif.sync_stable = 1'b1;
        sif.sync_dout   = 4'hA;
        push(EV_RDY, 4'hA);
        cyc();
        at_neg();
        chk("run_ready", 32'(ready), 1);
        chk("run_dout", 32'(dout), 32'hA);
        chk("run_change0", 32'(change), 0);
        chk("run_sync_resetn", 32'(sif.sync_resetn), 1);

        // Data change across a short stability dropout.
        cyc();
        sif.sync_stable = 1'b0;
        sif.sync_dout   = 4'h5;
        repeat (3) cyc();
        sif.sync_stable = 1'b1;
        push(EV_CHG, 4'h5);
        cyc();
        at_neg();
        chk("chg_pulse", 32'(change), 1);
        chk("chg_dout", 32'(dout), 32'h5);
        cyc();
        at_neg();
        chk("chg_one_cycle", 32'(change), 0);
        chk("chg_ready", 32'(ready), 1);
        chk("chg_fault", 32'(fault), 0);

        // 7 low cycles tolerated, 8 faults.
        cyc();
        sif.sync_stable = 1'b0;
        repeat (7) cyc();
        sif.sync_stable = 1'b1;
        cyc();
        at_neg();
        chk("glitch7_no_fault", 32'(fault), 0);
        chk("glitch7_ready", 32'(ready), 1);
        cyc();
        sif.sync_stable = 1'b0;
        sif.sync_dout   = 4'h3;
        push(EV_FLT, 4'h2);
        repeat (7) cyc();
        at_neg();
        chk("glitch8_pre", 32'(fault), 0);
        cyc();
        at_neg();
        chk("glitch8_fault", 32'(fault), 1);
        chk("glitch8_code", 32'(fault_code), 2);
        chk("glitch8_dout_hold", 32'(dout), 32'h5);
        chk("glitch8_ready", 32'(ready), 0);
        chk("glitch8_sync_resetn", 32'(sif.sync_resetn), 0);

        // Clear with enable high: IDLE then FLUSH, then settle timeout.
        cyc();
        fault_clear = 1'b1;
        cyc();
        fault_clear = 1'b0;
        at_neg();
        chk("clr_fault", 32'(fault), 0);
        chk("clr_code", 32'(fault_code), 0);
        chk("clr_idle_sync_resetn", 32'(sif.sync_resetn), 0);
        cyc();
        at_neg();
        chk("clr_dout_cleared", 32'(dout), 0);
        chk("clr_flush_sync_resetn", 32'(sif.sync_resetn), 0);
        repeat (4) cyc();
        push(EV_FLT, 4'h1);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fault) break;
            n++;
        end
        chk("timeout_settle_cycles", 32'(n), 16);
        chk("timeout_code", 32'(fault_code), 1);
        chk("timeout_sync_resetn", 32'(sif.sync_resetn), 0);

        // Enable dropped on the would-be timeout cycle.
        cyc();
        fault_clear = 1'b1;
        cyc();
        fault_clear = 1'b0;
        repeat (5) cyc();
        repeat (15) cyc();
        enable = 1'b0;
        cyc();
        at_neg();
        chk("drop_fault", 32'(fault), 0);
        chk("drop_code", 32'(fault_code), 0);
        chk("drop_dout", 32'(dout), 0);
        chk("drop_ready", 32'(ready), 0);
        cyc();
        at_neg();
        chk("drop_stays_clear", 32'(fault), 0);

        // Asynchronous reset mid-RUN, then restart from IDLE.
        cyc();
        enable          = 1'b1;
        sif.sync_stable = 1'b1;
        sif.sync_dout   = 4'h9;
        push(EV_RDY, 4'h9);
        repeat (6) cyc();
        at_neg();
        chk("pre_rst_ready", 32'(ready), 1);
        chk("pre_rst_dout", 32'(dout), 32'h9);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_sync_resetn", 32'(sif.sync_resetn), 0);
        chk("async_ready", 32'(ready), 0);
        chk("async_dout", 32'(dout), 0);
        chk("async_fault", 32'(fault), 0);
        chk("async_code", 32'(fault_code), 0);
        cyc();
        resetn = 1'b1;
        push(EV_RDY, 4'h9);
        count_low(n);
        chk("restart_low_cycles", 32'(n), 5);
        cyc();
        at_neg();
        chk("restart_ready", 32'(ready), 1);
        chk("restart_dout", 32'(dout), 32'h9);

        repeat (3) cyc();
        chk("sb_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
